// File: rtl/tea_pkg.sv
// Shared types and constants for the TEA block cipher core.
package tea_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned NUM_ROUNDS_DEF = 32;
   localparam word_t       DELTA_DEF      = 32'h9E3779B9;

endpackage

// File: rtl/tea_round.sv
// One combinational TEA cycle: both half-rounds, the second using the updated v0.
module tea_round
   import tea_pkg::*;
(
   input  word_t v0,
   input  word_t v1,
   input  word_t k0,
   input  word_t k1,
   input  word_t k2,
   input  word_t k3,
   input  word_t sum,
   output word_t v0_next,
   output word_t v1_next
);

   word_t v0_mix_s;
   word_t v1_mix_s;

   // Shifts written as concatenations so the logical right shift is explicit.
   assign v0_mix_s = ({v1[27:0], 4'b0000} + k0) ^ (v1 + sum) ^ ({5'b00000, v1[31:5]} + k1);
   assign v0_next  = v0 + v0_mix_s;
   assign v1_mix_s = ({v0_next[27:0], 4'b0000} + k2) ^ (v0_next + sum) ^ ({5'b00000, v0_next[31:5]} + k3);
   assign v1_next  = v1 + v1_mix_s;

endmodule

// File: rtl/tiny_encryption_algorithm.sv
// Iterative TEA encryptor: one double-round per clock, result held until the next start.
module tiny_encryption_algorithm
   import tea_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_DEF,
   parameter word_t       DELTA      = DELTA_DEF
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         key_valid,
   input  logic         ptxt_valid,
   input  logic [63:0]  ptxt,
   input  logic [127:0] key,
   output logic [63:0]  ctxt,
   output logic         ctxt_ready
);

   localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

   state_t      state_r;
   word_t       v0_r;
   word_t       v1_r;
   word_t       k0_r;
   word_t       k1_r;
   word_t       k2_r;
   word_t       k3_r;
   word_t       sum_r;
   logic [5:0]  round_cnt_r;
   logic [63:0] ctxt_r;
   logic        ctxt_ready_r;

   logic        start_s;
   word_t       sum_next_s;
   word_t       v0_next_s;
   word_t       v1_next_s;

   assign start_s    = key_valid & ptxt_valid;
   assign sum_next_s = sum_r + DELTA;

   tea_round u_round (
      .v0      (v0_r),
      .v1      (v1_r),
      .k0      (k0_r),
      .k1      (k1_r),
      .k2      (k2_r),
      .k3      (k3_r),
      .sum     (sum_next_s),
      .v0_next (v0_next_s),
      .v1_next (v1_next_s)
   );

   // Control FSM and datapath registers; reset overrides any start in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         v0_r         <= 32'h0000_0000;
         v1_r         <= 32'h0000_0000;
         k0_r         <= 32'h0000_0000;
         k1_r         <= 32'h0000_0000;
         k2_r         <= 32'h0000_0000;
         k3_r         <= 32'h0000_0000;
         sum_r        <= 32'h0000_0000;
         round_cnt_r  <= 6'd0;
         ctxt_r       <= 64'h0;
         ctxt_ready_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (start_s) begin
                  v0_r         <= ptxt[63:32];
                  v1_r         <= ptxt[31:0];
                  k0_r         <= key[127:96];
                  k1_r         <= key[95:64];
                  k2_r         <= key[63:32];
                  k3_r         <= key[31:0];
                  sum_r        <= 32'h0000_0000;
                  round_cnt_r  <= 6'd0;
                  ctxt_ready_r <= 1'b0;
                  state_r      <= BUSY;
               end
            end
            BUSY: begin
               v0_r        <= v0_next_s;
               v1_r        <= v1_next_s;
               sum_r       <= sum_next_s;
               round_cnt_r <= round_cnt_r + 6'd1;
               // The final cycle's round output goes straight to ctxt so DONE lands on edge N+1.
               if (round_cnt_r == LAST_ROUND) begin
                  ctxt_r       <= {v0_next_s, v1_next_s};
                  ctxt_ready_r <= 1'b1;
                  state_r      <= DONE;
               end
            end
            default: begin
               state_r      <= IDLE;
               ctxt_ready_r <= 1'b0;
            end
         endcase
      end
   end

   assign ctxt       = ctxt_r;
   assign ctxt_ready = ctxt_ready_r;

endmodule

// File: tb/tb_tiny_encryption_algorithm.sv
// Directed and random bench for the TEA core with a software reference and result queue.
module tb_tiny_encryption_algorithm;
   import tea_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         key_valid;
   logic         ptxt_valid;
   logic [63:0]  ptxt;
   logic [127:0] key;
   logic [63:0]  ctxt;
   logic         ctxt_ready;

   int          errors = 0;
   int          checks = 0;
   logic [63:0] exp_q[$];

   localparam logic [63:0] ZERO_CT = 64'h41EA3A0A94BAA940;

   tiny_encryption_algorithm dut (
      .clk        (clk),
      .rst        (rst),
      .key_valid  (key_valid),
      .ptxt_valid (ptxt_valid),
      .ptxt       (ptxt),
      .key        (key),
      .ctxt       (ctxt),
      .ctxt_ready (ctxt_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] tea_ref(input logic [127:0] k, input logic [63:0] p);
      logic [31:0] v0, v1, sum, k0, k1, k2, k3;
      v0 = p[63:32]; v1 = p[31:0];
      k0 = k[127:96]; k1 = k[95:64]; k2 = k[63:32]; k3 = k[31:0];
      sum = 32'h0;
      for (int i = 0; i < 32; i++) begin
         sum = sum + 32'h9E3779B9;
         v0  = v0 + ((((v1 << 4) + k0) ^ (v1 + sum)) ^ ((v1 >> 5) + k1));
         v1  = v1 + ((((v0 << 4) + k2) ^ (v0 + sum)) ^ ((v0 >> 5) + k3));
      end
      return {v0, v1};
   endfunction

   task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic start_op(input logic [127:0] k, input logic [63:0] p);
      key        = k;
      ptxt       = p;
      key_valid  = 1'b1;
      ptxt_valid = 1'b1;
      exp_q.push_back(tea_ref(k, p));
      tick();
      key_valid  = 1'b0;
      ptxt_valid = 1'b0;
   endtask

   task automatic wait_result(input string tag, input int edges0);
      int          edges = edges0;
      logic [63:0] held  = ctxt;
      logic        moved = 1'b0;
      logic [63:0] exp;
      while (ctxt_ready !== 1'b1 && edges < 40) begin
         tick();
         edges++;
         if (ctxt_ready !== 1'b1 && ctxt !== held) moved = 1'b1;
      end
      check64({tag, " latency"}, 64'(edges), 64'd33);
      check64({tag, " ctxt held in busy"}, 64'(moved), 64'd0);
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      else exp = 64'hDEAD_BEEF_DEAD_BEEF;
      check64({tag, " ctxt"}, ctxt, exp);
   endtask

   initial begin
      logic        seen;
      logic [127:0] rk;
      logic [63:0]  rp;

      rst = 1'b1; key_valid = 1'b0; ptxt_valid = 1'b0; key = 128'h0; ptxt = 64'h0;
      tick();
      tick();
      check64("reset ctxt", ctxt, 64'h0);
      check64("reset ready", 64'(ctxt_ready), 64'd0);
      check64("reset state", 64'(dut.state_r), 64'(IDLE));
      rst = 1'b0;

      // Zero vector known answer, then hold in DONE.
      start_op(128'h0, 64'h0);
      check64("zero ready after start", 64'(ctxt_ready), 64'd0);
      wait_result("zero", 1);
      check64("zero kat", ctxt, ZERO_CT);
      repeat (5) tick();
      check64("done hold ctxt", ctxt, ZERO_CT);
      check64("done hold ready", 64'(ctxt_ready), 64'd1);

      // Back-to-back start from DONE.
      start_op(128'h0123456789ABCDEF_FEDCBA9876543210, 64'h0011223344556677);
      check64("b2b ready drop", 64'(ctxt_ready), 64'd0);
      wait_result("b2b", 1);

      // Lone valids must not start.
      do_reset();
      key_valid = 1'b1; tick(); key_valid = 1'b0;
      ptxt_valid = 1'b1; tick(); ptxt_valid = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         tick();
         if (ctxt_ready !== 1'b0) seen = 1'b1;
      end
      check64("lone valid ready", 64'(seen), 64'd0);
      check64("lone valid state", 64'(dut.state_r), 64'(IDLE));

      // Input changes and valid pulse mid-operation are ignored.
      start_op(128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 64'hCAFEBABE_12345678);
      repeat (9) tick();
      key = 128'h1; ptxt = 64'h2; key_valid = 1'b1; ptxt_valid = 1'b1;
      tick();
      key_valid = 1'b0; ptxt_valid = 1'b0;
      wait_result("busy ignore", 11);

      // Reset mid-operation aborts, restart works.
      do_reset();
      start_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
      repeat (14) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check64("abort ctxt", ctxt, 64'h0);
      check64("abort ready", 64'(ctxt_ready), 64'd0);
      exp_q.delete();
      seen = 1'b0;
      repeat (40) begin
         tick();
         if (ctxt_ready !== 1'b0) seen = 1'b1;
      end
      check64("abort no pulse", 64'(seen), 64'd0);
      start_op(128'h0, 64'h0);
      wait_result("restart", 1);
      check64("restart kat", ctxt, ZERO_CT);

      // Random vectors with reset between each.
      for (int n = 0; n < 1000; n++) begin
         do_reset();
         rk = {$urandom, $urandom, $urandom, $urandom};
         rp = {$urandom, $urandom};
         start_op(rk, rp);
         wait_result("random", 1);
      end

      check64("queue drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tiny_encryption_algorithm.md
TINY_ENCRYPTION_ALGORITHM -- requirements
Module: tiny_encryption_algorithm

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 32, TEA cycle (double-round) count.
REQ-002 SHALL have parameter DELTA, default 32'h9E3779B9, key-schedule constant.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port key_valid, input, 1, key is stable and valid.
REQ-006 SHALL have port ptxt_valid, input, 1, plaintext is stable and valid.
REQ-007 SHALL have port ptxt, input, 64, plaintext; v0=ptxt[63:32], v1=ptxt[31:0].
REQ-008 SHALL have port key, input, 128, key; k0=key[127:96], k1=[95:64], k2=[63:32], k3=[31:0].
REQ-009 SHALL have port ctxt, output, 64, ciphertext {v0,v1}.
REQ-010 SHALL have port ctxt_ready, output, 1, ctxt holds a valid result.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-012 In IDLE or DONE, a start occurs only at a rising edge with key_valid=1 and ptxt_valid=1 both sampled high; either alone SHALL be ignored.
REQ-013 On start: register v0, v1, k0..k3, sum=0, round counter=0, clear ctxt_ready, go to BUSY.
REQ-014 In BUSY, each cycle SHALL execute one TEA cycle, all arithmetic mod 2^32: sum+=DELTA; v0+=((v1<<4)+k0)^(v1+sum)^((v1>>5)+k1); v1+=((v0'<<4)+k2)^(v0'+sum)^((v0'>>5)+k3), using updated v0' (>> logical).
REQ-015 After NUM_ROUNDS BUSY cycles SHALL go to DONE, drive ctxt={v0,v1}, assert ctxt_ready.
REQ-016 Latency: ctxt_ready high after the (NUM_ROUNDS+1)th rising edge counting the start edge (33 edges with default).
REQ-017 In DONE, ctxt and ctxt_ready SHALL hold until the next start or reset.
REQ-018 In BUSY, valid inputs and changes on ptxt/key SHALL be ignored; the operation is not restartable.
REQ-019 Start in DONE SHALL clear ctxt_ready on the same edge and begin a new operation (back-to-back allowed).
REQ-020 ctxt SHALL not change during BUSY (retains previous result or zero).

Reset
REQ-021 rst=1 at a rising edge SHALL force IDLE, ctxt=0, ctxt_ready=0, counters/sum/state registers=0, overriding any start in that cycle.
REQ-022 Reset mid-BUSY SHALL abort the operation with no ctxt_ready pulse; next start after release SHALL work normally.

Structure
REQ-023 Package tea_pkg SHALL hold DELTA, NUM_ROUNDS default, the state enum typedef, and 32-bit word typedef.
REQ-024 Sub-module tea_round SHALL be combinational: inputs v0, v1, k0..k3, sum; outputs next v0, v1 per REQ-014; instantiated once.
REQ-025 Round counter SHALL be 6 bits wide with default NUM_ROUNDS.

Verification
REQ-026 key=0, ptxt=0, both valids for one cycle -> after 33 edges ctxt=64'h41EA3A0A94BAA940, ctxt_ready=1.
REQ-027 Random key/ptxt, 1000 vectors vs software TEA model, reset between vectors -> all ctxt match, latency exactly 33 edges each.
REQ-028 key_valid=1 only (ptxt_valid=0), then ptxt_valid only -> ctxt_ready stays 0, state IDLE.
REQ-029 Start, change ptxt/key and pulse valids at cycle 10 -> result equals original vector's ciphertext at original latency.
REQ-030 Start, assert rst at cycle 15 -> ctxt=0, ctxt_ready=0; restart with zero vector -> 64'h41EA3A0A94BAA940.
REQ-031 Back-to-back: start again in DONE cycle -> ctxt_ready drops next edge, second result correct 33 edges later.
